// File: rtl/fb_pixel_writer.sv
// Framebuffer write stage. It accepts pixel writes over valid/ready, or sweeps
// the whole active area to clear it. Each accepted pixel or clear coordinate
// goes through a fixed two-stage pipeline that ends in a single-cycle RAM write.
//
// state | meaning
// IDLE  | accepting pixels; clear_start launches a sweep
// CLEAR | one clear coordinate issued per cycle in row-major order; pixels stalled
module fb_pixel_writer #(
  parameter int WIDTH   = 11,
  parameter int HACTIVE = 1280,
  parameter int VACTIVE = 640,
  parameter int ADDR_W  = 20,
  parameter int COLOR_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [COLOR_W-1:0] in_color,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               clear_done
);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] HACT_A = ADDR_W'(HACTIVE);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   cx, cy;
  logic [COLOR_W-1:0] clr_color;
  logic               cx_wrap, clear_last, in_range, accept;

  logic               s1_valid, s1_last;
  logic [WIDTH-1:0]   s1_x, s1_y;
  logic [COLOR_W-1:0] s1_color;

  assign cx_wrap    = (32'(cx) == HACTIVE - 1);
  assign clear_last = cx_wrap && (32'(cy) == VACTIVE - 1);
  assign in_range   = (32'(in_x) < HACTIVE) && (32'(in_y) < VACTIVE);
  assign accept     = in_valid & in_ready;

  // The clear is still draining through the pipeline after the FSM leaves CLEAR.
  assign busy = (state == CLEAR) | s1_last | clear_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake decode; clear_start wins over a simultaneous pixel
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~clear_start;
        if (clear_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (clear_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sweep counters and latched clear color
  always_ff @(posedge clk) begin
    if (reset) begin
      cx        <= '0;
      cy        <= '0;
      clr_color <= '0;
    end else if (state == IDLE && clear_start) begin
      cx        <= '0;
      cy        <= '0;
      clr_color <= clear_color;
    end else if (state == CLEAR) begin
      if (cx_wrap) begin
        cx <= '0;
        cy <= cy + WIDTH'(1);
      end else begin
        cx <= cx + WIDTH'(1);
      end
    end
  end

  // Stage 1: capture either the clear coordinate or an accepted in-range pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_color <= '0;
    end else if (state == CLEAR) begin
      s1_valid <= 1'b1;
      s1_last  <= clear_last;
      s1_x     <= cx;
      s1_y     <= cy;
      s1_color <= clr_color;
    end else begin
      s1_valid <= accept & in_range;
      s1_last  <= 1'b0;
      s1_x     <= in_x;
      s1_y     <= in_y;
      s1_color <= in_color;
    end
  end

  // Stage 2: linear row-major address and the write strobe; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
    end else begin
      wr_en      <= s1_valid;
      clear_done <= s1_last;
      if (s1_valid) begin
        wr_addr <= ADDR_W'(s1_y) * HACT_A + ADDR_W'(s1_x);
        wr_data <= s1_color;
      end
    end
  end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Framebuffer write stage that sits directly downstream of the screen-sweep coordinate generator and drawing logic. It accepts pixel writes (x, y, color) over a valid/ready handshake, or on request sweeps the whole active area itself to clear it to a background color. Coordinates are converted to a linear row-major address and issued as single-cycle writes to the framebuffer RAM through a fixed 2-cycle pipeline.

## Interface
- WIDTH, 11, bit width of x/y coordinates
- HACTIVE, 1280, active pixels per row
- VACTIVE, 640, active rows
- ADDR_W, 20, framebuffer address width; must satisfy 2^ADDR_W ≥ HACTIVE*VACTIVE
- COLOR_W, 1, pixel data width

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- clear_start  in  1  request a full-screen clear; sampled only in IDLE
- clear_color  in  COLOR_W  clear color; latched on the cycle clear_start is accepted
- in_valid  in  1  pixel request valid
- in_ready  out  1  block can accept a pixel this cycle
- in_x  in  WIDTH  pixel column
- in_y  in  WIDTH  pixel row
- in_color  in  COLOR_W  pixel data
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  ADDR_W  framebuffer write address
- wr_data  out  COLOR_W  framebuffer write data
- busy  out  1  clear in progress
- clear_done  out  1  single-cycle pulse on the final clear write

## Operation
- FSM states: IDLE, CLEAR.
- IDLE: in_ready = ~clear_start (combinational). A handshake is in_valid & in_ready at a rising edge.
- Accepted pixel with in_x < HACTIVE and in_y < VACTIVE enters the pipeline. An out-of-range pixel is still accepted but dropped: no write.
- IDLE → CLEAR when clear_start = 1. clear_start has priority over a simultaneous in_valid; that pixel is not accepted.
- clear_color and internal counters cx = 0, cy = 0 are loaded on the same edge.
- CLEAR: one coordinate is issued per cycle in row-major order.
  - cx increments each cycle.
  - At cx = HACTIVE-1, cx wraps to 0 and cy increments.
  - After issuing (HACTIVE-1, VACTIVE-1), FSM returns to IDLE.
  - in_ready = 0 throughout CLEAR.
  - clear_start is ignored in CLEAR.
- Pipeline stage 1 registers valid, x, y, color.
- Pipeline stage 2 registers wr_en, wr_addr = y*HACTIVE + x (computed in ADDR_W bits, no truncation for in-range coordinates) and wr_data.
- Write order equals acceptance/issue order. Pixels accepted after a clear follow the last clear write with no reordering.
- Reset, at any time including mid-clear:
  - FSM goes to IDLE and the pipeline is flushed.
  - On the next cycle: wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, clear_done = 0, in_ready = 1 (if clear_start = 0).
  - An aborted clear produces no clear_done.

## Timing
- Pixel handshake in cycle t → wr_en = 1 in cycle t+2 with that pixel's address and data. Sustained throughput is 1 write/cycle.
- clear_start sampled in cycle t (N = HACTIVE*VACTIVE):
  - FSM is in CLEAR for cycles t+1 … t+N.
  - Writes to addresses 0 … N-1 appear in cycles t+3 … t+N+2, consecutive, with wr_data = latched clear_color.
  - clear_done = 1 only in cycle t+N+2, coincident with the wr_addr = N-1 write.
  - busy = 1 in cycles t+1 … t+N+2.
  - in_ready returns to 1 in cycle t+N+1.
- No backpressure from the framebuffer: wr_en is never stalled.

## Test plan
- Reset, then single pixel (x=3, y=2, color=1) with HACTIVE=4, VACTIVE=3, ADDR_W=4 → exactly one wr_en pulse 2 cycles after the handshake, wr_addr=11, wr_data=1. Before that, all outputs are 0 and in_ready = 1.
- Back-to-back pixels (0,0), (1,0), (0,1) on 3 consecutive cycles → wr_addr 0, 1, 4 on 3 consecutive cycles starting 2 cycles after the first handshake.
- Out-of-range pixels (x=4, y=0) and (x=0, y=3) → both accepted (in_ready = 1); no wr_en.
- clear_start with clear_color=1 at cycle t, in_valid also high at t → pixel not accepted.
  - 12 consecutive writes, addresses 0…11 in cycles t+3…t+14, all data 1.
  - clear_done only at t+14; busy high t+1…t+14; in_ready low t…t+12.
  - clear_start pulsed again at t+5 has no effect.
- Reset asserted at cycle t+6 of a clear → wr_en = 0 from t+7, busy = 0, no clear_done.
  - A new clear afterwards restarts at address 0.
- Pixel accepted at cycle t+13, the first in_ready cycle after a clear → its write appears at t+15, immediately after the address-11 clear write.
